// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with frame snapshots, leading-zero
// suppression, per-digit blanking and an anti-ghosting blank interval.
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 262144,
  parameter int BLANK_CYCLES = 0,
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              cathodes,
  output logic [SW-1:0]           digit_sel,
  output logic                    frame_done
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0]           presc;
  logic [4*NUM_DIGITS-1:0] val_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic [NUM_DIGITS-1:0]   blk_s;
  logic                    lz_s;
  logic                    valid_s;

  logic                    presc_wrap;
  logic                    sel_last;
  logic                    load;
  logic                    past_blank;

  assign presc_wrap = (presc == PW'(SCAN_DIV - 1));
  assign sel_last   = (digit_sel == SW'(NUM_DIGITS - 1));
  assign load       = (presc == '0) && (digit_sel == '0);

  if (BLANK_CYCLES == 0) begin : g_noblank
    assign past_blank = 1'b1;
  end else begin : g_blank
    assign past_blank = (presc >= PW'(BLANK_CYCLES));
  end

  logic [NUM_DIGITS-1:0] sup;
  logic                  run;
  logic [3:0]            nib;
  logic                  dp_cur;
  logic                  blk_cur;
  logic                  sup_cur;
  logic                  lit;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            cat_d;

  // A digit is a leading zero only if it and every digit above it is a bare 0.
  always_comb begin
    sup = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (val_s[4*i +: 4] == 4'h0) & ~dp_s[i];
      if (i > 0) sup[i] = run & lz_s;
    end
  end

  always_comb begin
    nib     = '0;
    dp_cur  = 1'b0;
    blk_cur = 1'b0;
    sup_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel == SW'(i)) begin
        nib     = val_s[4*i +: 4];
        dp_cur  = dp_s[i];
        blk_cur = blk_s[i];
        sup_cur = sup[i];
      end
    end
  end

  always_comb begin
    seg = 7'b1111111;
    unique case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
    endcase
  end

  // Dark until the first snapshot after reset has been taken.
  always_comb begin
    lit   = enable & valid_s & past_blank & ~blk_cur & ~sup_cur;
    an_d  = '1;
    cat_d = 8'hFF;
    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_sel == SW'(i)) an_d[i] = 1'b0;
      end
      cat_d = {seg, ~dp_cur};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
      val_s      <= '0;
      dp_s       <= '0;
      blk_s      <= '0;
      lz_s       <= 1'b0;
      valid_s    <= 1'b0;
      anodes     <= '1;
      cathodes   <= 8'hFF;
    end else begin
      presc      <= presc_wrap ? '0 : presc + 1'b1;
      frame_done <= presc_wrap & sel_last;
      if (presc_wrap) digit_sel <= sel_last ? '0 : digit_sel + 1'b1;
      if (load) begin
        val_s   <= value;
        dp_s    <= dp_in;
        blk_s   <= blank_mask;
        lz_s    <= lz_blank;
        valid_s <= 1'b1;
      end
      anodes   <= an_d;
      cathodes <= cat_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: 4 digits, 8-cycle dwell, plus a
// second instance with a 2-cycle anti-ghosting interval.
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_blank;
  logic        enable;
  logic [3:0]  anodes, anodes_b;
  logic [7:0]  cathodes, cathodes_b;
  logic [1:0]  digit_sel, digit_sel_b;
  logic        frame_done, frame_done_b;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_blank(lz_blank), .enable(enable),
    .anodes(anodes), .cathodes(cathodes), .digit_sel(digit_sel),
    .frame_done(frame_done)
  );

  ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_blank(lz_blank), .enable(enable),
    .anodes(anodes_b), .cathodes(cathodes_b), .digit_sel(digit_sel_b),
    .frame_done(frame_done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic go(input int n);
    while (ecount < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    value      = 16'h12AF;
    dp_in      = 4'b0000;
    blank_mask = 4'b0000;
    lz_blank   = 1'b0;
    enable     = 1'b1;
    repeat (3) tick();
    chk("rst_an", anodes, 4'b1111);
    chk("rst_cat", cathodes, 8'hFF);
    chk("rst_sel", digit_sel, 2'd0);
    chk("rst_fd", frame_done, 1'b0);
    rst    = 1'b0;
    ecount = 0;

    // frame 1: edges 1..32
    go(1);
    chk("first_dark", anodes, 4'b1111);
    go(2);
    chk("d0_an", anodes, 4'b1110);
    chk("d0_cat_F", cathodes, 8'b01110001);
    go(8);
    chk("lag_sel", digit_sel, 2'd1);
    chk("lag_an", anodes, 4'b1110);
    go(9);
    chk("d1_an", anodes, 4'b1101);
    chk("d1_cat_A", cathodes, 8'b00010001);
    go(17);
    chk("d2_an", anodes, 4'b1011);
    chk("d2_cat_2", cathodes, 8'b00100101);
    go(25);
    chk("d3_an", anodes, 4'b0111);
    chk("d3_cat_1", cathodes, 8'b10011111);
    go(31);
    chk("fd_pre", frame_done, 1'b0);
    go(32);
    chk("fd_pulse", frame_done, 1'b1);
    go(33);
    chk("fd_post", frame_done, 1'b0);

    // snapshot: change mid-frame 2
    go(42);
    value = 16'h0000;
    go(50);
    chk("snap_old", cathodes, 8'b00100101);
    go(64);
    chk("fd_frame2", frame_done, 1'b1);
    go(66);
    chk("snap_new_d0", cathodes, 8'b00000011);
    go(76);
    chk("snap_new_d1_an", anodes, 4'b1101);
    chk("snap_new_d1", cathodes, 8'b00000011);

    // leading-zero suppression, loaded at edge 97
    lz_blank = 1'b1;
    value    = 16'h0050;
    go(100);
    chk("lz_d0_an", anodes, 4'b1110);
    chk("lz_d0", cathodes, 8'b00000011);
    go(108);
    chk("lz_d1", cathodes, 8'b01001001);
    go(116);
    chk("lz_d2_an", anodes, 4'b1111);
    chk("lz_d2_cat", cathodes, 8'hFF);
    go(124);
    chk("lz_d3_an", anodes, 4'b1111);
    dp_in = 4'b1000;
    go(148);
    chk("lzdp_d2_an", anodes, 4'b1011);
    chk("lzdp_d2", cathodes, 8'b00000011);
    go(156);
    chk("lzdp_d3_an", anodes, 4'b0111);
    chk("lzdp_d3", cathodes, 8'b00000010);

    // per-digit blank, loaded at edge 161
    lz_blank   = 1'b0;
    dp_in      = 4'b0000;
    value      = 16'h12AF;
    blank_mask = 4'b0010;
    go(172);
    chk("blk_d1_an", anodes, 4'b1111);
    chk("blk_d1_cat", cathodes, 8'hFF);
    go(180);
    chk("blk_d2_an", anodes, 4'b1011);
    enable = 1'b0;
    go(184);
    chk("en0_an", anodes, 4'b1111);
    chk("en0_cat", cathodes, 8'hFF);
    chk("en0_sel", digit_sel, 2'd3);
    go(192);
    chk("en0_fd", frame_done, 1'b1);
    go(193);
    chk("en0_fd_end", frame_done, 1'b0);
    enable     = 1'b1;
    blank_mask = 4'b0000;

    // anti-ghosting on dut_b, frame starting at edge 225
    go(226);
    chk("ag_dark0", anodes_b, 4'b1111);
    chk("ag_main_lit", anodes, 4'b1110);
    go(227);
    chk("ag_lit_an", anodes_b, 4'b1110);
    chk("ag_lit_cat", cathodes_b, 8'b01110001);
    go(232);
    chk("ag_lit_end", anodes_b, 4'b1110);
    chk("ag_sel", digit_sel_b, 2'd1);
    go(233);
    chk("ag_d1_dark", anodes_b, 4'b1111);
    chk("ag_d1_dark_cat", cathodes_b, 8'hFF);
    chk("ag_main_d1", anodes, 4'b1101);
    go(235);
    chk("ag_d1_lit", anodes_b, 4'b1101);
    chk("ag_d1_cat", cathodes_b, 8'b00010001);

    // reset mid-scan: digit_sel=2, prescaler=5 after edge 245
    go(245);
    chk("mid_sel", digit_sel, 2'd2);
    rst = 1'b1;
    go(246);
    chk("mr_sel", digit_sel, 2'd0);
    chk("mr_an", anodes, 4'b1111);
    chk("mr_cat", cathodes, 8'hFF);
    chk("mr_fd", frame_done, 1'b0);
    rst = 1'b0;
    go(247);
    chk("mr_first_dark", anodes, 4'b1111);
    go(248);
    chk("mr_d0_an", anodes, 4'b1110);
    chk("mr_d0_cat", cathodes, 8'b01110001);
    go(278);
    chk("mr_fd", frame_done, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
